// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the CPU datapath memory ports, the arbiter and physical memory.
// The master view is the arbiter itself; the slave view is the environment around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_resp;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [1:0]        d_mem_byte_enable;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [1:0]        pmem_byte_enable;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  i_mem_read, i_mem_address,
        output i_mem_rdata, i_mem_resp,
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
        output d_mem_rdata, d_mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        output i_mem_read, i_mem_address,
        input  i_mem_rdata, i_mem_resp,
        output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
        input  d_mem_rdata, d_mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serializing instruction fetches and data loads/stores onto one
// physical memory port, with wrap-around completion counters per requester.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_if.master    bus,
    output logic [CNT_W-1:0] i_grant_count,
    output logic [CNT_W-1:0] d_grant_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } state_t;

    state_t state_r;
    logic   last_grant_r;   // 1'b0 = fetch side, 1'b1 = data side
    logic   i_pend_s;
    logic   d_pend_s;
    logic   grant_d_s;

    // Pending detection and round-robin tie-break against the previous winner.
    always_comb begin
        i_pend_s  = bus.i_mem_read;
        d_pend_s  = bus.d_mem_read | bus.d_mem_write;
        grant_d_s = 1'b0;
        if (i_pend_s && d_pend_s) begin
            grant_d_s = ~last_grant_r;
        end else begin
            grant_d_s = d_pend_s;
        end
    end

    // Transaction FSM; pmem_* outputs double as the latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r              <= ST_IDLE;
            last_grant_r         <= 1'b0;
            bus.pmem_read        <= 1'b0;
            bus.pmem_write       <= 1'b0;
            bus.pmem_address     <= {ADDR_W{1'b0}};
            bus.pmem_wdata       <= {DATA_W{1'b0}};
            bus.pmem_byte_enable <= 2'b00;
            bus.i_mem_resp       <= 1'b0;
            bus.i_mem_rdata      <= {DATA_W{1'b0}};
            bus.d_mem_resp       <= 1'b0;
            bus.d_mem_rdata      <= {DATA_W{1'b0}};
            i_grant_count        <= {CNT_W{1'b0}};
            d_grant_count        <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_pend_s || d_pend_s) begin
                        last_grant_r <= grant_d_s;
                        if (grant_d_s) begin
                            state_r              <= ST_BUSY_D;
                            bus.pmem_address     <= bus.d_mem_address;
                            bus.pmem_wdata       <= bus.d_mem_wdata;
                            bus.pmem_byte_enable <= bus.d_mem_byte_enable;
                            // Read+write together is resolved as a write.
                            bus.pmem_write       <= bus.d_mem_write;
                            bus.pmem_read        <= ~bus.d_mem_write;
                        end else begin
                            state_r              <= ST_BUSY_I;
                            bus.pmem_address     <= bus.i_mem_address;
                            bus.pmem_wdata       <= {DATA_W{1'b0}};
                            bus.pmem_byte_enable <= 2'b00;
                            bus.pmem_write       <= 1'b0;
                            bus.pmem_read        <= 1'b1;
                        end
                    end
                end
                ST_BUSY_I: begin
                    if (bus.pmem_resp) begin
                        state_r         <= ST_RESP_I;
                        bus.pmem_read   <= 1'b0;
                        bus.pmem_write  <= 1'b0;
                        bus.i_mem_rdata <= bus.pmem_rdata;
                        bus.i_mem_resp  <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (bus.pmem_resp) begin
                        state_r         <= ST_RESP_D;
                        bus.pmem_read   <= 1'b0;
                        bus.pmem_write  <= 1'b0;
                        bus.d_mem_rdata <= bus.pmem_rdata;
                        bus.d_mem_resp  <= 1'b1;
                    end
                end
                ST_RESP_I: begin
                    state_r         <= ST_IDLE;
                    bus.i_mem_resp  <= 1'b0;
                    bus.i_mem_rdata <= {DATA_W{1'b0}};
                    i_grant_count   <= i_grant_count + CNT_W'(1);
                end
                ST_RESP_D: begin
                    state_r         <= ST_IDLE;
                    bus.d_mem_resp  <= 1'b0;
                    bus.d_mem_rdata <= {DATA_W{1'b0}};
                    d_grant_count   <= d_grant_count + CNT_W'(1);
                end
                default: begin
                    state_r        <= ST_IDLE;
                    bus.pmem_read  <= 1'b0;
                    bus.pmem_write <= 1'b0;
                    bus.i_mem_resp <= 1'b0;
                    bus.d_mem_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level requester/memory model predicts
// grant order, pmem contents, completion latency and grant counters.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] i_grant_count;
    logic [3:0] d_grant_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: who won last, and completions per side.
    bit last_d_m = 1'b0;
    int i_cnt_m  = 0;
    int d_cnt_m  = 0;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .i_grant_count (i_grant_count),
        .d_grant_count (d_grant_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        bus.i_mem_address     = 16'($urandom);
        bus.d_mem_address     = 16'($urandom);
        bus.d_mem_wdata       = 16'($urandom);
        bus.d_mem_byte_enable = 2'($urandom);
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_icnt"}, 32'(i_grant_count), 32'(i_cnt_m % 16));
        check_val({tag, "_dcnt"}, 32'(d_grant_count), 32'(d_cnt_m % 16));
    endtask

    // One complete transaction starting in an IDLE cycle; n = pmem latency, rd = pmem data.
    task automatic txn(input int n, input logic [15:0] rd, input bit drop);
        bit          i_req, d_req, side_d, is_wr;
        logic [15:0] ea, ew;
        logic [1:0]  eb;
        i_req  = bus.i_mem_read;
        d_req  = bus.d_mem_read | bus.d_mem_write;
        side_d = (i_req && d_req) ? !last_d_m : d_req;
        is_wr  = side_d && bus.d_mem_write;
        ea     = side_d ? bus.d_mem_address : bus.i_mem_address;
        ew     = bus.d_mem_wdata;
        eb     = bus.d_mem_byte_enable;
        last_d_m = side_d;
        check_val("pmem_idle", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);

        step();
        check_val("pmem_read", 32'(bus.pmem_read), 32'(!is_wr));
        check_val("pmem_write", 32'(bus.pmem_write), 32'(is_wr));
        check_val("pmem_addr", 32'(bus.pmem_address), 32'(ea));
        if (is_wr) begin
            check_val("pmem_wdata", 32'(bus.pmem_wdata), 32'(ew));
            check_val("pmem_be", 32'(bus.pmem_byte_enable), 32'(eb));
        end
        check_val("busy_resp", {30'd0, bus.i_mem_resp, bus.d_mem_resp}, 32'd0);
        scramble_inputs();
        for (int k = 0; k < n; k++) begin
            bus.pmem_rdata = 16'($urandom);
            step();
            check_val("pmem_hold", {30'd0, bus.pmem_read, bus.pmem_write}, is_wr ? 32'd1 : 32'd2);
            check_val("addr_hold", 32'(bus.pmem_address), 32'(ea));
            check_val("hold_resp", {30'd0, bus.i_mem_resp, bus.d_mem_resp}, 32'd0);
            scramble_inputs();
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rd;

        step();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 16'($urandom);
        check_val("resp_pulse", {30'd0, bus.i_mem_resp, bus.d_mem_resp}, side_d ? 32'd1 : 32'd2);
        check_val("resp_rdata", side_d ? 32'(bus.d_mem_rdata) : 32'(bus.i_mem_rdata), 32'(rd));
        check_val("other_rdata", side_d ? 32'(bus.i_mem_rdata) : 32'(bus.d_mem_rdata), 32'd0);
        check_val("pmem_drop", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        if (side_d) d_cnt_m++;
        else        i_cnt_m++;
        if (drop) begin
            if (side_d) begin
                bus.d_mem_read  = 1'b0;
                bus.d_mem_write = 1'b0;
            end else begin
                bus.i_mem_read = 1'b0;
            end
        end

        step();
        check_val("post_resp", {30'd0, bus.i_mem_resp, bus.d_mem_resp}, 32'd0);
        check_val("post_rdata", {bus.i_mem_rdata, bus.d_mem_rdata}, 32'd0);
        check_counts("post");
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.i_mem_read  = 1'b0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.pmem_resp   = 1'b0;
        #1;
        check_val("rst_pmem", {14'd0, bus.pmem_read, bus.pmem_write, bus.pmem_address}, 32'd0);
        check_val("rst_pmem_wd", {14'd0, bus.pmem_byte_enable, bus.pmem_wdata}, 32'd0);
        check_val("rst_resp", {30'd0, bus.i_mem_resp, bus.d_mem_resp}, 32'd0);
        check_val("rst_rdata", {bus.i_mem_rdata, bus.d_mem_rdata}, 32'd0);
        check_val("rst_cnt", {24'd0, i_grant_count, d_grant_count}, 32'd0);
        step();
        rst_n    = 1'b1;
        last_d_m = 1'b0;
        i_cnt_m  = 0;
        d_cnt_m  = 0;
    endtask

    initial begin
        bus.i_mem_read        = 1'b0;
        bus.i_mem_address     = 16'h0000;
        bus.d_mem_read        = 1'b0;
        bus.d_mem_write       = 1'b0;
        bus.d_mem_address     = 16'h0000;
        bus.d_mem_wdata       = 16'h0000;
        bus.d_mem_byte_enable = 2'b00;
        bus.pmem_rdata        = 16'h0000;
        bus.pmem_resp         = 1'b0;
        apply_reset();

        // Single fetch, latency 2.
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h0040;
        txn(2, 16'h1234, 1'b1);

        // Masked store.
        bus.d_mem_write       = 1'b1;
        bus.d_mem_address     = 16'h0101;
        bus.d_mem_wdata       = 16'hAB00;
        bus.d_mem_byte_enable = 2'b10;
        txn(1, 16'h5A5A, 1'b1);

        // Read and write together resolve to a write.
        bus.d_mem_read        = 1'b1;
        bus.d_mem_write       = 1'b1;
        bus.d_mem_address     = 16'h0F0E;
        bus.d_mem_wdata       = 16'h00CD;
        bus.d_mem_byte_enable = 2'b01;
        txn(0, 16'h7777, 1'b1);

        // Fresh reset, then both sides held: D, I, D alternation.
        apply_reset();
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h0200;
        bus.d_mem_read    = 1'b1;
        bus.d_mem_address = 16'h0300;
        for (int t = 0; t < 3; t++) txn(int'($urandom_range(0, 3)), 16'($urandom), 1'b0);
        check_val("alt_d_first", 32'(d_grant_count), 32'd2);
        check_val("alt_i_second", 32'(i_grant_count), 32'd1);
        bus.i_mem_read = 1'b0;
        bus.d_mem_read = 1'b0;
        step();

        // Randomized mixes; losers stay held until served.
        for (int it = 0; it < 40; it++) begin
            scramble_inputs();
            bus.i_mem_read  = 1'($urandom);
            bus.d_mem_read  = 1'($urandom);
            bus.d_mem_write = 1'($urandom);
            if (!bus.i_mem_read && !bus.d_mem_read && !bus.d_mem_write) bus.i_mem_read = 1'b1;
            while (bus.i_mem_read || bus.d_mem_read || bus.d_mem_write)
                txn(int'($urandom_range(0, 4)), 16'($urandom), 1'b1);
        end

        // Reset while a store is in flight; the stale pmem_resp must be ignored.
        bus.d_mem_write   = 1'b1;
        bus.d_mem_address = 16'h0BEE;
        step();
        check_val("midrst_busy", 32'(bus.pmem_write), 32'd1);
        apply_reset();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'hDEAD;
        step();
        bus.pmem_resp = 1'b0;
        check_val("stale_resp", {30'd0, bus.i_mem_resp, bus.d_mem_resp}, 32'd0);
        check_val("stale_pmem", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        step();
        check_val("stale_resp2", {30'd0, bus.i_mem_resp, bus.d_mem_resp}, 32'd0);
        check_counts("stale");

        // 17 fetches on a 4-bit counter wrap to 1.
        for (int f = 0; f < 17; f++) begin
            bus.i_mem_read    = 1'b1;
            bus.i_mem_address = 16'($urandom);
            txn(int'($urandom_range(0, 2)), 16'($urandom), 1'b1);
        end
        check_val("wrap", 32'(i_grant_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the pipelined CPU datapath.
- Accepts its instruction-memory port (read-only) and data-memory port (read/write with byte enables), and serializes them onto one physical memory port (pmem).
- Both requester sides use the level/resp handshake the datapath already speaks. Round-robin arbitration guarantees neither fetch nor load/store starves.
- Two wrap-around grant counters are exposed for performance measurement.

Parameters:
ADDR_W, 16, address width of all ports
DATA_W, 16, data width of all ports
CNT_W, 16, width of grant counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_mem_read  in  1  fetch request, level, held until i_mem_resp
i_mem_address  in  ADDR_W  fetch address
i_mem_rdata  out  DATA_W  fetch data, valid while i_mem_resp=1
i_mem_resp  out  1  one-cycle fetch completion pulse
d_mem_read  in  1  load request, level
d_mem_write  in  1  store request, level
d_mem_address  in  ADDR_W  load/store address
d_mem_wdata  in  DATA_W  store data
d_mem_byte_enable  in  2  store byte mask
d_mem_rdata  out  DATA_W  load data, valid while d_mem_resp=1
d_mem_resp  out  1  one-cycle load/store completion pulse
pmem_read  out  1  physical read, held until pmem_resp
pmem_write  out  1  physical write, held until pmem_resp
pmem_address  out  ADDR_W  physical address
pmem_wdata  out  DATA_W  physical write data
pmem_byte_enable  out  2  physical write mask
pmem_rdata  in  DATA_W  physical read data, valid with pmem_resp
pmem_resp  in  1  physical completion, one-cycle pulse
i_grant_count  out  CNT_W  completed fetch transactions
d_grant_count  out  CNT_W  completed data transactions

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: pmem_*, *_resp, *_rdata and both counters.
  - last_grant resets to I.
- States:
  - IDLE: no transaction in flight.
  - BUSY_I: fetch in flight on pmem.
  - BUSY_D: load/store in flight on pmem.
  - RESP_I: i_mem_resp pulse cycle.
  - RESP_D: d_mem_resp pulse cycle.
- IDLE arbitration:
  - Only I pending → BUSY_I.
  - Only D pending (d_mem_read | d_mem_write) → BUSY_D.
  - Both pending → grant the side opposite to last_grant. The first tie after reset goes to D.
- IDLE latching: on the transition, latch address, wdata, byte_enable and op into request registers.
  - If d_mem_read and d_mem_write are both 1, treat the request as a write.
  - last_grant updates to the granted side.
- BUSY_x:
  - Drive pmem_address, pmem_wdata and pmem_byte_enable from the request registers only; never combinationally from inputs.
  - Hold pmem_read or pmem_write at 1.
  - Requester inputs changing during BUSY are ignored.
  - On pmem_resp: capture pmem_rdata into rdata_q, drop pmem_read/write in the next cycle, go to RESP_x.
- RESP_x:
  - x_mem_resp=1 for exactly one cycle; x_mem_rdata=rdata_q. On writes, rdata_q still holds the captured pmem_rdata.
  - The matching grant counter increments, wrapping from 2^CNT_W-1 to 0.
  - Next state is IDLE.
- IDLE after RESP_x: a request still asserted in the IDLE cycle after RESP_x is a new transaction; the requester advances on resp.
- *_rdata is 0 whenever its resp is 0.
- Latency: with pmem_resp arriving N cycles after pmem_read/write first asserts (N≥0, same-cycle resp allowed), completion takes N+3 cycles:
  - request seen in IDLE at cycle 0;
  - pmem asserted from cycle 1;
  - resp pulse at cycle N+2.
- At most one pmem transaction is outstanding; pmem_read and pmem_write are never both 1.
- pmem_resp received while in IDLE or RESP_x (e.g. stale response after reset) is ignored.

Test Plan:
- Single fetch:
  - Stimulus: i_mem_read=1, addr=0x0040; pmem returns 0x1234 with N=2.
  - Required: pmem_read high exactly cycles 1-3; i_mem_resp pulse at cycle 4 with rdata=0x1234; i_grant_count=1.
- Store with mask:
  - Stimulus: d_mem_write=1, addr=0x0101, wdata=0xAB00, byte_enable=2'b10.
  - Required: pmem_write=1 with identical address/data/mask; single d_mem_resp pulse; pmem_read stays 0.
- Simultaneous requests after reset:
  - Stimulus: I and D requests asserted together, both held.
  - Required: D served first, then I, then D (alternation); grant counters advance 1:1.
- Reset mid-BUSY_D:
  - Stimulus: rst_n=0 while pmem_write=1.
  - Required: all outputs 0 immediately; a later pmem_resp in IDLE is ignored; no d_mem_resp pulse.
- Illegal read+write:
  - Stimulus: d_mem_read=d_mem_write=1.
  - Required: only pmem_write asserted.
- Counter wrap:
  - Stimulus: with CNT_W=4, complete 17 fetches.
  - Required: i_grant_count=1.
